// File: rtl/data_mem_wait_ctrl_if.sv
// -----------------------------------------------------------------------------
// data_mem_wait_ctrl_if
// Request/response bundle between the core's memory stage (master) and the
// wait-state data memory (slave).
//   request     master->slave  transaction request
//   we_re       master->slave  1 = store, 0 = load
//   mask        master->slave  byte-lane enables for stores
//   address     master->slave  byte address, bits [1:0] ignored
//   store_data  master->slave  lane-aligned store data
//   load_data   slave->master  read word, meaningful while valid=1
//   valid       slave->master  one-cycle completion pulse
//   busy        slave->master  transaction in flight
//   addr_error  slave->master  out-of-range access, pulses with valid
// -----------------------------------------------------------------------------
interface data_mem_wait_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDRESS    = 32
);
    logic                    request;
    logic                    we_re;
    logic [DATA_WIDTH/8-1:0] mask;
    logic [ADDRESS-1:0]      address;
    logic [DATA_WIDTH-1:0]   store_data;
    logic [DATA_WIDTH-1:0]   load_data;
    logic                    valid;
    logic                    busy;
    logic                    addr_error;

    modport master (
        output request, we_re, mask, address, store_data,
        input  load_data, valid, busy, addr_error
    );

    modport slave (
        input  request, we_re, mask, address, store_data,
        output load_data, valid, busy, addr_error
    );
endinterface

// File: rtl/data_mem_wait_ctrl.sv
// -----------------------------------------------------------------------------
// data_mem_wait_ctrl
// Word-addressed data SRAM that answers each accepted request after LATENCY
// wait states with a one-cycle valid pulse. One transaction at a time; requests
// arriving while busy are dropped, not queued.
//   clk    in  rising-edge clock
//   rst    in  synchronous active-high reset (array contents are kept)
//   io_dm  slave side of data_mem_wait_ctrl_if (request/store in, load/valid out)
// -----------------------------------------------------------------------------
module data_mem_wait_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDRESS     = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_wait_ctrl_if.slave  io_dm
);
    localparam int         IDX_W    = $clog2(DEPTH_WORDS);
    localparam int         LANES    = DATA_WIDTH / 8;
    localparam bit         ZERO_LAT = (LATENCY == 0);
    localparam logic [3:0] LAT_L    = 4'(LATENCY);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [3:0]              r_cnt;
    logic                    r_err;
    logic [DATA_WIDTH-1:0]   r_load_data;

    // Request captured at accept; only these copies are used afterwards
    logic                    r_we;
    logic [LANES-1:0]        r_mask;
    logic [ADDRESS-3:0]      r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;

    logic [DATA_WIDTH-1:0]   r_mem [DEPTH_WORDS];

    logic                    w_accept;
    logic                    w_commit;
    logic                    w_we;
    logic [LANES-1:0]        w_mask;
    logic [ADDRESS-3:0]      w_addr;
    logic [DATA_WIDTH-1:0]   w_wdata;
    logic                    w_oob;
    logic [IDX_W-1:0]        w_idx;
    logic                    w_unused_addr_lsb;

    assign w_unused_addr_lsb = &{1'b0, io_dm.address[1:0]};

    assign w_accept = (r_state == S_IDLE) && io_dm.request;

    // With zero wait states the access commits on the accept edge itself,
    // so it must use the live request instead of the captured copy.
    assign w_commit = ZERO_LAT ? w_accept : ((r_state == S_WAIT) && (r_cnt == 4'd1));
    assign w_we     = ZERO_LAT ? io_dm.we_re                     : r_we;
    assign w_mask   = ZERO_LAT ? io_dm.mask                      : r_mask;
    assign w_addr   = ZERO_LAT ? io_dm.address[ADDRESS-1:2]      : r_addr;
    assign w_wdata  = ZERO_LAT ? io_dm.store_data                : r_wdata;

    // Depth is a power of two, so any set bit above the index is out of range
    assign w_oob = |w_addr[ADDRESS-3:IDX_W];
    assign w_idx = w_addr[IDX_W-1:0];

    // State register plus control state touched by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_err       <= 1'b0;
            r_load_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept)
                r_cnt <= LAT_L;
            else if (r_state == S_WAIT)
                r_cnt <= r_cnt - 4'd1;
            if (w_commit) begin
                r_err <= w_oob;
                if (!w_we)
                    r_load_data <= w_oob ? '0 : r_mem[w_idx];
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (io_dm.request) w_state_nxt = ZERO_LAT ? S_RESP : S_WAIT;
            S_WAIT: if (r_cnt == 4'd1) w_state_nxt = S_RESP;
            S_RESP: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        io_dm.valid      = (r_state == S_RESP);
        io_dm.busy       = (r_state != S_IDLE);
        io_dm.addr_error = (r_state == S_RESP) && r_err;
        io_dm.load_data  = r_load_data;
    end

    // Request capture, data only, no reset
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_we    <= io_dm.we_re;
            r_mask  <= io_dm.mask;
            r_addr  <= io_dm.address[ADDRESS-1:2];
            r_wdata <= io_dm.store_data;
        end
    end

    // Byte-lane write; a reset on the commit edge aborts the write
    always_ff @(posedge clk) begin
        if (!rst && w_commit && w_we && !w_oob) begin
            for (int i = 0; i < LANES; i++) begin
                if (w_mask[i])
                    r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_data_mem_wait_ctrl.sv
module tb_data_mem_wait_ctrl;
    localparam int LAT    = 2;
    localparam int DEPTH  = 1024;
    localparam int DEPTH0 = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    data_mem_wait_ctrl_if #(.DATA_WIDTH(32), .ADDRESS(32)) b2 ();
    data_mem_wait_ctrl_if #(.DATA_WIDTH(32), .ADDRESS(32)) b0 ();

    data_mem_wait_ctrl #(.DATA_WIDTH(32), .ADDRESS(32), .DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .io_dm(b2)
    );
    data_mem_wait_ctrl #(.DATA_WIDTH(32), .ADDRESS(32), .DEPTH_WORDS(DEPTH0), .LATENCY(0)) dut0 (
        .clk(clk), .rst(rst), .io_dm(b0)
    );

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    int checks   = 0;
    int failures = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (edge %0d)", nm, act, exp, edge_n);
        end
    endfunction

    // Reference model: expected completions and word contents
    typedef struct {
        int          at;
        bit          is_load;
        logic [31:0] data;
        bit          err;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    logic [31:0] mdl [int];
    int          next_free = 0;
    int          win_lo    = -100;
    int          win_hi    = -100;
    bit          mon_en    = 1'b0;

    // Monitor: samples on the falling edge, edge_n = number of rising edges so far
    always @(negedge clk) begin
        if (mon_en) begin
            chk("busy", 32'(b2.busy), 32'(edge_n >= win_lo && edge_n <= win_hi));
            while (sbq.size() > 0 && sbq[0].at < edge_n) begin
                checks++;
                failures++;
                $display("FAIL valid_missing: none at edge %0d, now edge %0d", sbq[0].at, edge_n);
                void'(sbq.pop_front());
            end
            if (b2.valid) begin
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_valid: valid=1 at edge %0d, none expected", edge_n);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("valid_time", 32'(edge_n), 32'(mon_e.at));
                    chk("addr_error", 32'(b2.addr_error), 32'(mon_e.err));
                    if (mon_e.is_load)
                        chk("load_data", b2.load_data, mon_e.data);
                end
            end else begin
                chk("addr_error_no_valid", 32'(b2.addr_error), 32'd0);
            end
        end
    end

    // Issue one transaction once the model says the slave is free. While it is
    // busy, random (or held-high) requests are driven and must be ignored.
    task automatic issue(input bit we, input logic [31:0] addr, input logic [31:0] d,
                         input logic [3:0] m, input int gap, input bit hold);
        int          k;
        int          wi;
        bit          oob;
        logic [31:0] w;
        while (edge_n + 1 < next_free) begin
            b2.request    = hold ? 1'b1 : 1'($urandom_range(0, 1));
            b2.we_re      = 1'($urandom);
            b2.mask       = 4'($urandom);
            b2.address    = $urandom;
            b2.store_data = $urandom;
            @(negedge clk);
        end
        for (int g = 0; g < gap; g++) begin
            b2.request = 1'b0;
            b2.address = $urandom;
            @(negedge clk);
        end
        b2.request    = 1'b1;
        b2.we_re      = we;
        b2.mask       = m;
        b2.address    = addr;
        b2.store_data = d;
        k   = edge_n + 1;
        oob = (addr[31:2] >= 30'(DEPTH));
        wi  = int'(addr[31:2]);
        if (we) begin
            if (!oob) begin
                w = mdl.exists(wi) ? mdl[wi] : 32'h0;
                for (int i = 0; i < 4; i++)
                    if (m[i]) w[8*i +: 8] = d[8*i +: 8];
                mdl[wi] = w;
            end
            sbq.push_back('{k + LAT, 1'b0, 32'h0, oob});
        end else begin
            w = (oob || !mdl.exists(wi)) ? 32'h0 : mdl[wi];
            sbq.push_back('{k + LAT, 1'b1, w, oob});
        end
        win_lo    = k;
        win_hi    = k + LAT;
        next_free = k + LAT + 2;
        @(negedge clk);
        b2.request = hold;
    endtask

    int          k5;
    logic [31:0] ra;

    initial begin
        b2.request = 1'b0; b2.we_re = 1'b0; b2.mask = 4'h0; b2.address = '0; b2.store_data = '0;
        b0.request = 1'b0; b0.we_re = 1'b0; b0.mask = 4'h0; b0.address = '0; b0.store_data = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(b2.valid), 32'd0);
        chk("rst_busy", 32'(b2.busy), 32'd0);
        chk("rst_addr_error", 32'(b2.addr_error), 32'd0);
        chk("rst_load_data", b2.load_data, 32'h0);
        chk("rst0_valid", 32'(b0.valid), 32'd0);
        chk("rst0_load_data", b0.load_data, 32'h0);
        rst       = 1'b0;
        next_free = edge_n + 1;
        mon_en    = 1'b1;

        // Zero wait states: response right after the accept edge, one dead cycle
        b0.request = 1'b1; b0.we_re = 1'b1; b0.address = 32'h8;
        b0.store_data = 32'h5A5A1234; b0.mask = 4'hF;
        @(negedge clk);
        chk("l0_store_valid", 32'(b0.valid), 32'd1);
        chk("l0_store_busy", 32'(b0.busy), 32'd1);
        b0.store_data = 32'hFFFFFFFF;
        @(negedge clk);
        chk("l0_ignored_valid", 32'(b0.valid), 32'd0);
        chk("l0_ignored_busy", 32'(b0.busy), 32'd0);
        b0.we_re = 1'b0;
        @(negedge clk);
        chk("l0_load_valid", 32'(b0.valid), 32'd1);
        chk("l0_load_data", b0.load_data, 32'h5A5A1234);
        chk("l0_load_err", 32'(b0.addr_error), 32'd0);
        b0.address = 32'(DEPTH0 * 4);
        @(negedge clk);
        chk("l0_gap_valid", 32'(b0.valid), 32'd0);
        @(negedge clk);
        chk("l0_oob_valid", 32'(b0.valid), 32'd1);
        chk("l0_oob_err", 32'(b0.addr_error), 32'd1);
        chk("l0_oob_data", b0.load_data, 32'h0);
        b0.request = 1'b0;
        @(negedge clk);
        chk("l0_idle_valid", 32'(b0.valid), 32'd0);

        // Known contents for the word range used by random loads
        for (int i = 0; i < 16; i++)
            issue(1'b1, 32'(i * 4), $urandom, 4'hF, 0, 1'b0);

        // Store then load back
        issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0);
        issue(1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0);

        // Partial-lane store
        issue(1'b1, 32'h20, 32'h11223344, 4'hF, 1, 1'b0);
        issue(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, 1'b0);
        issue(1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0);
        // Empty mask leaves the word alone
        issue(1'b1, 32'h20, 32'h00000000, 4'b0000, 0, 1'b0);
        issue(1'b0, 32'h22, 32'h0, 4'h0, 0, 1'b0);

        // Request held high across back-to-back loads
        issue(1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b1);
        issue(1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b1);
        issue(1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b1);

        // Out-of-range load and store
        issue(1'b0, 32'(DEPTH * 4), 32'h0, 4'h0, 0, 1'b0);
        issue(1'b1, 32'(DEPTH * 4), 32'h12345678, 4'hF, 0, 1'b0);
        issue(1'b0, 32'h0, 32'h0, 4'h0, 0, 1'b0);

        // Reset while a store is waiting
        issue(1'b1, 32'h30, 32'h0, 4'hF, 0, 1'b0);
        while (edge_n + 1 < next_free) begin
            b2.request = 1'b0;
            @(negedge clk);
        end
        b2.request = 1'b1; b2.we_re = 1'b1; b2.address = 32'h30;
        b2.store_data = 32'hCAFEF00D; b2.mask = 4'hF;
        k5     = edge_n + 1;
        win_lo = k5;
        win_hi = k5 + 1;
        @(negedge clk);
        b2.request = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_wait_load_data", b2.load_data, 32'h0);
        next_free = k5 + 3;
        issue(1'b0, 32'h30, 32'h0, 4'h0, 0, 1'b0);

        // Random traffic
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 7) == 0)
                ra = $urandom | 32'h0000_1000;
            else
                ra = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom)};
            issue(1'($urandom), ra, $urandom, 4'($urandom), $urandom_range(0, 2),
                  1'($urandom_range(0, 1)));
        end

        // Drain
        b2.request = 1'b0;
        for (int i = 0; i < LAT + 4; i++) @(negedge clk);
        chk("drain_pending", 32'(sbq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
